// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the serial transmit sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_reg.sv
// Parallel-load right-shift register with zero fill; load has priority over shift.
module shift_reg
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                q[i] <= q[i+1];
            end
            q[WIDTH-1] <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Serial transmit sequencer: loads a word on start, sends it LSB-first with a
// valid qualifier, then pulses done for one cycle before returning to idle.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   sr;
    logic               load, shift;
    logic               q_nxt, qv_nxt, done_nxt;
    logic               sr_unused;

    // Bit 0 of the register is emitted directly from din on the load edge,
    // so the serial output always looks one stage ahead at sr[1].
    assign sr_unused = sr[0];

    shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (din),
        .q     (sr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            q       <= q_nxt;
            q_valid <= qv_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift     = 1'b0;
        q_nxt     = 1'b0;
        qv_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    q_nxt     = din[0];
                    qv_nxt    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Abort wins even on the edge that would have finished the word.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    shift     = 1'b1;
                    cnt_nxt   = cnt + CNT_W'(1);
                    q_nxt     = sr[1];
                    qv_nxt    = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: table vectors, hand sequences and random traffic against a queue model.
module tb_shift_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         abort = 1'b0;
    logic         ready, q, q_valid, done;

    int errors = 0;
    int checks = 0;

    shift_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .abort   (abort),
        .ready   (ready),
        .q       (q),
        .q_valid (q_valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of bits still to send plus the visible outputs.
    bit   mbits[$];
    logic m_q, m_qv, m_done, m_ready;

    task automatic model_reset();
        mbits.delete();
        m_q = 1'b0; m_qv = 1'b0; m_done = 1'b0; m_ready = 1'b1;
    endtask

    task automatic model_edge(input logic s, input logic [W-1:0] d, input logic a);
        if (m_done) begin
            m_done = 1'b0; m_ready = 1'b1; m_q = 1'b0; m_qv = 1'b0;
        end else if (m_ready) begin
            if (s) begin
                for (int i = 0; i < W; i++) mbits.push_back(d[i]);
                m_q = mbits.pop_front();
                m_qv = 1'b1;
                m_ready = 1'b0;
            end
        end else if (a) begin
            mbits.delete();
            m_q = 1'b0; m_qv = 1'b0; m_ready = 1'b1;
        end else if (mbits.size() == 0) begin
            m_q = 1'b0; m_qv = 1'b0; m_done = 1'b1;
        end else begin
            m_q = mbits.pop_front();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock once, advance the model, and compare {q,q_valid,done,ready}.
    task automatic step(input logic s, input logic [W-1:0] d, input logic a, input string name);
        start = s; din = d; abort = a;
        @(posedge clk);
        model_edge(s, d, a);
        #1;
        chk(name, {28'd0, q, q_valid, done, ready}, {28'd0, m_q, m_qv, m_done, m_ready});
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset(input string name);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk(name, {28'd0, q, q_valid, done, ready}, 32'h1);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] d;
        logic         a;
        logic [3:0]   exp;   // {q, q_valid, done, ready}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic [W-1:0] d, logic a, logic [3:0] e);
        vec_t v;
        v.s = s; v.d = d; v.a = a; v.exp = e;
        return v;
    endfunction

    int          ndone;
    int          nbits;
    logic [15:0] stream;

    initial begin
        model_reset();
        #12 rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, "post_reset");
        mid_reset("reset_idle");

        for (int i = 0; i < 10; i++) step(1'b0, W'($urandom), i[0], "idle_hold");

        // Single word 1011_0010
        tbl.push_back(mk(1, 8'hB2, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0010));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0001));
        // Ignored start during SHIFT, ignored start+abort during DONE (word 8'h96)
        tbl.push_back(mk(1, 8'h96, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(1, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0010));
        tbl.push_back(mk(1, 8'hFF, 1, 4'b0001));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0001));
        // Abort at k+3 then immediate restart with 8'h01
        tbl.push_back(mk(1, 8'hFF, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b1100));
        tbl.push_back(mk(0, 8'h00, 1, 4'b0001));
        tbl.push_back(mk(1, 8'h01, 0, 4'b1100));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 8'h00, 0, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0010));
        tbl.push_back(mk(0, 8'h00, 0, 4'b0001));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].d, tbl[i].a, "tbl_model");
            chk($sformatf("tbl[%0d]", i), {28'd0, q, q_valid, done, ready}, {28'd0, tbl[i].exp});
        end

        // Back-to-back with start held high: second word accepted ten edges later.
        ndone = 0; nbits = 0; stream = '0;
        for (int i = 0; i < 20; i++) begin
            step(i <= 10, (i < 10) ? 8'hA5 : 8'h3C, 1'b0, "b2b");
            if (done) ndone++;
            if (q_valid && nbits < 16) begin
                stream[nbits] = q;
                nbits++;
            end
        end
        chk("b2b_done_pulses", ndone, 2);
        chk("b2b_bit_count", nbits, 16);
        chk("b2b_stream", {16'd0, stream}, 32'h3CA5);

        // Reset between edges k+4 and k+5, then a fresh word.
        step(1'b1, 8'h5A, 1'b0, "mid_word");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, "mid_word");
        mid_reset("reset_mid_word");
        step(1'b1, 8'hC3, 1'b0, "fresh_word");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, "fresh_word");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 15) == 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Serial transmit sequencer for the flip-flop shift chain. Accepts a parallel word on a start handshake, loads it into an internal parallel-load shift register, and drives it out LSB-first on a single serial line, one bit per clock, with a valid qualifier. It then pulses done and returns to idle. It is the controlling block in front of the D-flip-flop chain datapath and provides abort and back-pressure via ready.

## Interface
- WIDTH, 8, word length in bits; legal range WIDTH ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to transmit din; accepted only when ready=1
- din  in  WIDTH  parallel word, sampled on the accepting edge
- abort  in  1  cancels a transmission in progress
- ready  out  1  high in IDLE; start is accepted on an edge where start=1 and ready=1
- q  out  1  serial data, registered
- q_valid  out  1  high while q carries a word bit, registered
- done  out  1  one-cycle pulse after the last bit of a non-aborted word, registered

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (asynchronous, any time, including mid-word) has immediate effect:
  - state=IDLE, ready=1, q=0, q_valid=0, done=0
  - shift register=0, bit counter=0
- IDLE:
  - ready=1
  - start=1 at an edge loads din, clears the counter and moves to SHIFT.
  - abort is ignored in IDLE; start wins if both are high.
- SHIFT:
  - Each cycle q=sr[0] and q_valid=1; the register shifts right with zero fill and the counter increments.
  - When the counter reaches WIDTH-1 and that bit is emitted, the next edge moves to DONE.
  - start is ignored.
  - abort=1 at an edge moves to IDLE with q=0, q_valid=0, done=0. Bits not yet sent are discarded.
- DONE:
  - Lasts one cycle with done=1, q_valid=0, q=0, ready=0.
  - The next edge moves to IDLE. abort and start are ignored.
- Counter width is $clog2(WIDTH). The counter never wraps within a word because it is cleared on load.
- din is don't-care outside the accepting edge.

## Timing
- Start accepted at edge k:
  - Edges k .. k+WIDTH-1: q=din[0..WIDTH-1] in order, q_valid=1, one bit per cycle.
  - Edge k+WIDTH: q_valid=0, done=1.
  - Edge k+WIDTH+1: done=0, ready=1.
- Earliest next accepting edge is k+WIDTH+2, so throughput is one word per WIDTH+2 cycles.
- Abort sampled at edge j inside SHIFT: from edge j, q_valid=0 and ready=1. The earliest new start is accepted at edge j+1.
- A start pulse while ready=0 is lost; the block does not queue it.
- Outputs change only on clk rising edges or on rst assertion. No combinational path exists from inputs to outputs.

## Structure
- Shared package shift_seq_pkg holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - the default WIDTH constant
- Sub-module shift_reg: WIDTH-bit parallel-load right-shift register.
  - Ports: clk, rst, load, shift, din, q.
  - Implemented with nonblocking assignments so each stage takes the previous-cycle value of its neighbour.
  - load has priority over shift.
- The FSM, counter and output registers live in shift_seq.

## Test plan
- Reset then idle, WIDTH=8: assert rst mid-cycle → ready=1, q=0, q_valid=0, done=0 immediately; no change while start=0 for 10 cycles.
- Single word: din=8'b1011_0010, start pulse at edge k → q sequence 0,1,0,0,1,1,0,1 at edges k..k+7 with q_valid=1; done=1 at k+8; ready=1 at k+9.
- Back-to-back: two words 8'hA5 then 8'h3C, start held high continuously → second word accepted at k+10; q stream matches LSB-first order of both words; exactly two done pulses.
- Abort: din=8'hFF, abort at edge k+3 → three bits of 1 emitted, q_valid=0 from k+3, no done pulse; new start at k+4 accepted.
- Ignored requests: start pulse at k+2 during SHIFT, and abort during DONE → no effect; first word completes normally with done at k+8.
- Reset mid-word: rst asserted between edges k+4 and k+5 → all outputs at reset values immediately; after release, the next start transmits a fresh word correctly.
